iter_muldiv_unit: RTL
=====================

ITER_MULDIV_UNIT -- requirements
Module: iter_muldiv_unit

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32: operand/result width, even and >= 8.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush  input  1  abort the in-flight operation.
REQ-005 SHALL have port in_valid  input  1  operands and op presented.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-007 SHALL have port a  input  DATAWIDTH  multiplicand or dividend.
REQ-008 SHALL have port b  input  DATAWIDTH  multiplier or divisor.
REQ-009 SHALL have port op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  DATAWIDTH  operation result.
REQ-013 SHALL have port div_by_zero  output  1  divide/remainder op had b == 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept on a clock edge with in_valid && in_ready && !flush, registering a, b, op; later changes on a/b/op are ignored.
REQ-016 SHALL stay in CALC for exactly DATAWIDTH cycles (iteration counter 0..DATAWIDTH-1, one radix-2 shift/add or shift/subtract step per cycle).
REQ-017 SHALL raise out_valid in the (DATAWIDTH+1)-th cycle after the accept cycle, independent of op and operand values.
REQ-018 SHALL hold result and div_by_zero stable while out_valid && !out_ready.
REQ-019 SHALL return DONE -> IDLE on the edge where out_valid && out_ready; in_ready is 0 in that cycle, so the earliest next accept is the following cycle.
REQ-020 MUL SHALL return low DATAWIDTH bits of the product; MULH/MULHSU/MULHU SHALL return high DATAWIDTH bits of the 2*DATAWIDTH product with a,b signed/signed, a signed b unsigned, unsigned/unsigned.
REQ-021 Signed divide SHALL truncate toward zero; remainder sign SHALL equal dividend sign; magnitudes computed unsigned, signs fixed before DONE.
REQ-022 Divisor 0: DIV/DIVU SHALL return all ones, REM/REMU SHALL return a; div_by_zero = 1.
REQ-023 DIV with a = most-negative and b = all ones SHALL return a; REM SHALL return 0; div_by_zero = 0.
REQ-024 div_by_zero SHALL be 0 for all multiply ops and whenever out_valid = 0.
REQ-025 flush SHALL move the FSM to IDLE on the next edge from any state, discarding the operation; out_valid is 0 in the following cycle; flush with a completing output handshake discards it identically.
REQ-026 flush SHALL take priority over in_valid and out_ready; rst SHALL take priority over flush.
REQ-027 SHALL produce no X on result/out_valid/in_ready after the first reset.

Reset
REQ-028 rst high at an edge SHALL force IDLE, iteration counter 0, in_ready = 1, out_valid = 0, result = 0, div_by_zero = 0, in any state including mid-CALC and DONE.
REQ-029 An operation interrupted by rst SHALL never produce out_valid.
REQ-030 in_valid asserted together with rst SHALL not be accepted.

Verification (DATAWIDTH = 32)
REQ-031 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB at cycle 33 after accept; MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU same -> 0x7FFFFFFC.
REQ-033 DIVU a=5, b=0 -> 0xFFFFFFFF, div_by_zero=1; REMU a=5, b=0 -> 5, div_by_zero=1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 Backpressure: out_ready low 5 cycles after out_valid -> result constant, in_ready 0 throughout; out_ready high -> IDLE next cycle, back-to-back op accepted one cycle later.
REQ-035 flush in CALC iteration 10 -> IDLE next cycle, out_valid never 1 for that op; next op completes with correct result.
REQ-036 rst in CALC iteration 20 and in DONE with out_ready=0 -> all outputs at reset values next cycle, no stale result later.

Source files
------------

// File: rtl/iter_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit.
// Each operation runs for DATAWIDTH CALC cycles, independent of the operands.
// Multiplication is shift/add and division is restoring shift/subtract.
// Both work on operand magnitudes; the result sign is applied on the last step.
module iter_muldiv_unit #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [2:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] result,
    output logic                 div_by_zero
);

    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2*W-1:0]   acc_q;
    logic [2*W-1:0]   acc_d;
    logic [W-1:0]     operand_q;
    logic [2:0]       op_q;
    logic             neg_q;
    logic             bZero_q;
    logic             inReady_q;
    logic             outValid_q;
    logic [W-1:0]     result_q;
    logic [W-1:0]     result_d;
    logic             dbz_q;
    logic             dbz_d;

    logic             aSigned;
    logic             bSigned;
    logic             aNeg;
    logic             bNeg;
    logic [W-1:0]     aMag;
    logic [W-1:0]     bMag;
    logic [2*W-1:0]   accInit;
    logic [W-1:0]     operandInit;
    logic             negInit;

    logic [W:0]       mulSum;
    logic [W:0]       divShift;
    logic [W:0]       divDiff;
    logic [2*W-1:0]   prodSigned;
    logic [W-1:0]     divSel;

    // Decode operand signedness at accept time and prepare magnitudes for the datapath.
    // In the accumulator, a multiply keeps the multiplier in the low half.
    // A divide keeps the dividend there instead.
    always_comb begin
        aSigned     = op[2] ? !op[0] : (op[1:0] != 2'b11);
        bSigned     = op[2] ? !op[0] : !op[1];
        aNeg        = aSigned & a[W-1];
        bNeg        = bSigned & b[W-1];
        aMag        = aNeg ? -a : a;
        bMag        = bNeg ? -b : b;
        accInit     = {{W{1'b0}}, (op[2] ? aMag : bMag)};
        operandInit = op[2] ? bMag : aMag;
        negInit     = (op[2] && op[1]) ? aNeg : (aNeg ^ bNeg);
    end

    // One radix-2 iteration: add-and-shift-right for multiply, shift-left-and-subtract for divide.
    // A divisor of zero always "succeeds", which gives an all-ones quotient.
    // It also leaves the dividend magnitude as the remainder.
    always_comb begin
        mulSum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, operand_q} : {(W+1){1'b0}});
        divShift = {acc_q[2*W-1:W], acc_q[W-1]};
        divDiff  = divShift - {1'b0, operand_q};
        acc_d    = {mulSum, acc_q[W-1:1]};
        if (op_q[2]) begin
            if (divDiff[W]) begin
                acc_d = {divShift[W-1:0], acc_q[W-2:0], 1'b0};
            end else begin
                acc_d = {divDiff[W-1:0], acc_q[W-2:0], 1'b1};
            end
        end
    end

    // Final result selection and sign fix-up, used on the last CALC iteration.
    // Signed division by zero must still return all ones, so it bypasses the sign fix.
    always_comb begin
        prodSigned = neg_q ? -acc_d : acc_d;
        divSel     = op_q[1] ? acc_d[2*W-1:W] : acc_d[W-1:0];
        divSel     = neg_q ? -divSel : divSel;
        result_d   = (op_q[1:0] == 2'b00) ? prodSigned[W-1:0] : prodSigned[2*W-1:W];
        if (op_q[2]) begin
            result_d = (!op_q[1] && bZero_q) ? {W{1'b1}} : divSel;
        end
        dbz_d = op_q[2] & bZero_q;
    end

    // Control FSM with registered handshake outputs; rst beats flush, and flush beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            bZero_q    <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q   <= CALC;
                        cnt_q     <= '0;
                        acc_q     <= accInit;
                        operand_q <= operandInit;
                        op_q      <= op;
                        neg_q     <= negInit;
                        bZero_q   <= (b == '0);
                        inReady_q <= 1'b0;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_q    <= DONE;
                        cnt_q      <= '0;
                        outValid_q <= 1'b1;
                        result_q   <= result_d;
                        dbz_q      <= dbz_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q    <= IDLE;
                        inReady_q  <= 1'b1;
                        outValid_q <= 1'b0;
                        result_q   <= '0;
                        dbz_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inReady_q  <= 1'b1;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = inReady_q;
    assign out_valid   = outValid_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule
